// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - two-requester round-robin interval timer
// One shared counter runs from 0 to the winner's latched limit, then pulses done.
module timer_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] lim0,
  input  logic [WIDTH-1:0] lim1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt_n, lim_q, lim_n;
  logic [1:0]       gnt_n, done_n;
  logic             prio, prio_n;  // requester that wins a tie
  logic             win;
  logic             owner_req;

  assign win       = (req0 && req1) ? prio : req1;
  assign owner_req = gnt[1] ? req1 : req0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lim_n   = lim_q;
    gnt_n   = gnt;
    done_n  = 2'b00;
    prio_n  = prio;
    case (state)
      IDLE: begin
        cnt_n = '0;
        gnt_n = 2'b00;
        if (req0 || req1) begin
          state_n = RUN;
          lim_n   = win ? lim1 : lim0;
          gnt_n   = win ? 2'b10 : 2'b01;
          prio_n  = ~win;
        end
      end
      RUN: begin
        if (!owner_req) begin
          // abandoned interval: silent return, no completion pulse
          state_n = IDLE;
          gnt_n   = 2'b00;
          cnt_n   = '0;
        end else if (cnt != lim_q) begin
          cnt_n = cnt + WIDTH'(1);
        end else begin
          state_n = DONE;
          done_n  = gnt;
        end
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = 2'b00;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 2'b00;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lim_q <= '0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      prio  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lim_q <= lim_n;
      gnt   <= gnt_n;
      done  <= done_n;
      prio  <= prio_n;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - vector-table bench for timer_scheduler
// Each record holds the inputs before an edge and the outputs expected after it.
module tb_timer_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] lim0 = 8'd0;
  logic [7:0] lim1 = 8'd0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [7:0] cnt;

  timer_scheduler #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .req0(req0),
    .req1(req1),
    .lim0(lim0),
    .lim1(lim1),
    .gnt (gnt),
    .done(done),
    .busy(busy),
    .cnt (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [7:0] l0;
    logic [7:0] l1;
    logic [1:0] g;
    logic [1:0] d;
    logic [7:0] c;
  } vec_t;

  typedef struct packed {
    logic [1:0] g;
    logic [1:0] d;
    logic [7:0] c;
    logic       b;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic a0, input logic a1,
                     input logic [7:0] l0, input logic [7:0] l1,
                     input logic [1:0] g, input logic [1:0] d, input logic [7:0] c);
    vec_t v;
    v = '{rst: r, r0: a0, r1: a1, l0: l0, l1: l1, g: g, d: d, c: c};
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    exp_t e;

    // reset state
    add(1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add(1, 1, 1, 5, 5, 2'b00, 2'b00, 0);
    add(0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // single requester, lim0=3: cnt 0,1,2,3,3 with done in the fifth cycle
    add(0, 1, 0, 3, 0, 2'b01, 2'b00, 0);
    for (int k = 1; k <= 3; k++) add(0, 1, 0, 3, 0, 2'b01, 2'b00, 8'(k));
    add(0, 1, 0, 3, 0, 2'b01, 2'b01, 3);
    add(0, 0, 0, 3, 0, 2'b00, 2'b00, 0);
    add(0, 0, 0, 3, 0, 2'b00, 2'b00, 0);

    // lim1=0: two grant cycles, cnt stays 0
    add(0, 0, 1, 0, 0, 2'b10, 2'b00, 0);
    add(0, 0, 1, 0, 0, 2'b10, 2'b10, 0);
    add(0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // both requesting from reset: 01,10,01,10 with one idle cycle between
    add(1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    for (int r = 0; r < 2; r++) begin
      add(0, 1, 1, 2, 1, 2'b01, 2'b00, 0);
      add(0, 1, 1, 2, 1, 2'b01, 2'b00, 1);
      add(0, 1, 1, 2, 1, 2'b01, 2'b00, 2);
      add(0, 1, 1, 2, 1, 2'b01, 2'b01, 2);
      add(0, 1, 1, 2, 1, 2'b00, 2'b00, 0);
      add(0, 1, 1, 2, 1, 2'b10, 2'b00, 0);
      add(0, 1, 1, 2, 1, 2'b10, 2'b00, 1);
      add(0, 1, 1, 2, 1, 2'b10, 2'b10, 1);
      add(0, r == 0, r == 0, 2, 1, 2'b00, 2'b00, 0);
    end
    add(0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // abandon at cnt=4, pending req1 granted at the following edge
    add(0, 1, 0, 10, 2, 2'b01, 2'b00, 0);
    for (int k = 1; k <= 4; k++) add(0, 1, 1, 10, 2, 2'b01, 2'b00, 8'(k));
    add(0, 0, 1, 10, 2, 2'b00, 2'b00, 0);
    add(0, 0, 1, 10, 2, 2'b10, 2'b00, 0);
    add(0, 0, 1, 10, 2, 2'b10, 2'b00, 1);
    add(0, 0, 1, 10, 2, 2'b10, 2'b00, 2);
    add(0, 0, 1, 10, 2, 2'b10, 2'b10, 2);
    add(0, 0, 0, 10, 2, 2'b00, 2'b00, 0);

    // reset at cnt=5 in RUN after granting 0, then a tie must still go to 0
    add(0, 1, 0, 10, 0, 2'b01, 2'b00, 0);
    for (int k = 1; k <= 5; k++) add(0, 1, 0, 10, 0, 2'b01, 2'b00, 8'(k));
    add(1, 1, 1, 10, 0, 2'b00, 2'b00, 0);
    add(0, 1, 1, 1, 1, 2'b01, 2'b00, 0);
    add(0, 1, 1, 1, 1, 2'b01, 2'b00, 1);
    add(0, 1, 1, 1, 1, 2'b01, 2'b01, 1);
    add(0, 0, 0, 1, 1, 2'b00, 2'b00, 0);

    // full-range limit, lim0 changed after the grant edge, no wrap
    add(0, 1, 0, 255, 0, 2'b01, 2'b00, 0);
    for (int k = 1; k <= 255; k++) add(0, 1, 0, 3, 0, 2'b01, 2'b00, 8'(k));
    add(0, 1, 0, 3, 0, 2'b01, 2'b01, 255);
    add(0, 0, 0, 3, 0, 2'b00, 2'b00, 0);
    add(0, 0, 0, 3, 0, 2'b00, 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v    = vecs[i];
      rst  = v.rst;
      req0 = v.r0;
      req1 = v.r1;
      lim0 = v.l0;
      lim1 = v.l1;
      exp_q.push_back('{g: v.g, d: v.d, c: v.c, b: (v.g != 2'b00)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (gnt !== e.g || done !== e.d || cnt !== e.c || busy !== e.b) begin
        n_bad++;
        $display("FAIL vec%0d: got gnt=%b done=%b cnt=%0d busy=%b, want gnt=%b done=%b cnt=%0d busy=%b",
                 i, gnt, done, cnt, busy, e.g, e.d, e.c, e.b);
      end
    end

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
